// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arbState_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    // Read value returned to a master whose access was forcibly terminated.
    localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/wb_arb_timer.sv
// Grant watchdog: counts stalled grant cycles and flags the terminal cycle.
module wb_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the cycle whose increment would reach LIMIT.
    assign tc_o = enable_i && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between a CPU bridge and an aux DMA.
// Optional grant watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
    output logic                     m0_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
    output logic                     m1_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [WB_ADDR_WIDTH-1:0] s_adr_o,
    output logic [WB_DATA_WIDTH-1:0] s_dat_o,
    input  logic                     s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    arbState_t state_q, state_d;
    logic      lastGrant_q, lastGrant_d;

    logic                     ownerStb, ownerWe, granted, ownerAck, timeoutHit;
    logic [WB_ADDR_WIDTH-1:0] ownerAdr;
    logic [WB_DATA_WIDTH-1:0] ownerDat, ownerRdat;

    always_comb begin
        ownerStb = 1'b0;
        ownerWe  = 1'b0;
        ownerAdr = '0;
        ownerDat = '0;
        case (state_q)
            GNT0: begin
                ownerStb = m0_stb_i;
                ownerWe  = m0_we_i;
                ownerAdr = m0_adr_i;
                ownerDat = m0_dat_i;
            end
            GNT1: begin
                ownerStb = m1_stb_i;
                ownerWe  = m1_we_i;
                ownerAdr = m1_adr_i;
                ownerDat = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Outputs are gated by rst_i so an in-flight access dies the moment reset is applied.
    assign granted = rst_i && (state_q != IDLE);

`ifdef WB_ARB_TIMEOUT_EN
    logic timerClear, timerEnable, timerTc;

    assign timerClear  = (state_q == IDLE);
    assign timerEnable = granted && ownerStb && !s_ack_i;

    wb_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uTimer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (timerClear),
        .enable_i(timerEnable),
        .tc_o    (timerTc)
    );

    assign timeoutHit = timerTc;
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        s_stb_o   = granted && ownerStb && !timeoutHit;
        s_we_o    = rst_i && ownerWe;
        s_adr_o   = rst_i ? ownerAdr : '0;
        s_dat_o   = rst_i ? ownerDat : '0;
        ownerAck  = granted && ((ownerStb && s_ack_i) || timeoutHit);
        ownerRdat = timeoutHit ? TIMEOUT_RDATA[WB_DATA_WIDTH-1:0] : s_dat_i;
        m0_ack_o  = ownerAck && (state_q == GNT0);
        m1_ack_o  = ownerAck && (state_q == GNT1);
        m0_dat_o  = (granted && state_q == GNT0) ? ownerRdat : '0;
        m1_dat_o  = (granted && state_q == GNT1) ? ownerRdat : '0;
        grant_o   = rst_i ? {state_q == GNT1, state_q == GNT0} : 2'b00;
        timeout_o = granted && timeoutHit;
    end

    // A late ack after the owner withdrew stb is ignored because ownerAck needs ownerStb.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (m0_stb_i && (!m1_stb_i || lastGrant_q == M_AUX)) begin
                    state_d     = GNT0;
                    lastGrant_d = M_CPU;
                end else if (m1_stb_i) begin
                    state_d     = GNT1;
                    lastGrant_d = M_AUX;
                end
            end
            GNT0, GNT1: begin
                if (!ownerStb || s_ack_i || timeoutHit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            lastGrant_q <= M_AUX;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule
